mul_16_seq: RTL and testbench
=============================

Name: mul_16_seq

Overview:
Sequential 16x16 shift-and-add multiplier controller. It time-shares a single add_16 instance, retiring one multiplier bit per clock.
Returns the low 16 bits of the product, which is the correct two's-complement result for signed and unsigned operands alike.
Sits beside the ALU as a multi-cycle MUL resource with a start/ready/done handshake.

Parameters:
WIDTH, 16, operand/result width. Only 16 is supported, because the datapath is add_16. Any other value is an elaboration error.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when ready=1
a  input  16  multiplicand, sampled on the accepted start
b  input  16  multiplier, sampled on the accepted start
ready  output  1  high only in IDLE
busy  output  1  high in RUN and DONE
done  output  1  one-cycle pulse, high in DONE
product  output  16  result register; updated on entry to DONE, then held

Behaviour:
- Reset (async assert of rst_n, from any state):
  - state=IDLE; mcand, mplier, acc, count, product = 0.
  - ready=1, busy=0, done=0.
  - Reset mid-RUN aborts the operation: no done, product=0.
  - Deassertion is honoured on the next clk edge.
- Internal registers:
  - mcand[15:0], mplier[15:0], acc[15:0], count[3:0].
  - One add_16 instance with inputs acc and mcand; its output is sum.
  - No other adder is permitted; count increments via a plain counter.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 -> load mcand=a, mplier=b, acc=0, count=0; go to RUN.
  - start=0 -> stay in IDLE.
- RUN, every cycle:
  - acc <= mplier[0] ? sum : acc.
  - mcand <= mcand<<1 (bit 15 discarded).
  - mplier <= mplier>>1 (zero fill).
  - count <= count+1.
  - count==15 -> go to DONE; else stay in RUN.
- DONE:
  - product <= acc, loaded on the transition into DONE so it is valid while done=1.
  - done=1 for exactly one cycle, then return to IDLE.
- Latency:
  - Cycle 0 is the cycle in which start is accepted.
  - RUN occupies cycles 1-16; done=1 in cycle 17.
  - Next start is accepted in cycle 18. Throughput is 1 op / 18 cycles.
- Arithmetic:
  - All arithmetic is mod 2^16; no overflow flag.
  - Signed operands need no special handling.
- Boundary conditions:
  - start while busy=1 (RUN or DONE) is ignored: no queueing, operands untouched.
  - start held high continuously starts a new op each time IDLE is re-entered.
  - a, b may change freely after acceptance.
  - product holds its last value until the next DONE; it is never cleared except by reset.
  - a=0 or b=0 -> product 0 with full latency.

Optional Feature:
Macro MUL_16_SEQ_EARLY_TERM_EN.
- Defined:
  - In RUN, go to DONE when count==15 OR the next mplier (mplier>>1) is 0.
  - Done cycle = max(1, msb_index(b)+1) + 1, where msb_index is 0-based; b=0 counts as 1 RUN cycle.
  - Examples: b=0 or b=1 -> done in cycle 2; b=0x8000 -> done in cycle 17.
  - Results are identical to the undefined case.
- Undefined: fixed 16 RUN cycles; the early-exit comparator is not built.

Test Plan:
- Reset then a=3, b=5, start pulse in cycle 0 -> done=1 in cycle 17 only; product=0x000F; ready returns in cycle 18.
- a=0xFFFF, b=0xFFFF -> product=0x0001. Then a=300, b=300 -> product=0x5F90 (90000 mod 2^16).
- Signed: a=0xFFFD (-3), b=0x0007 -> product=0xFFEB (-21). Then a=0x8000, b=0x0002 -> product=0x0000.
- a=7, b=9 accepted; in cycle 5 apply start with a=1, b=1 -> ignored; product=0x003F in cycle 17; exactly one done pulse.
- Start a=0x1234, b=0x00FF; drop rst_n in cycle 8 -> immediately ready=1, busy=0, done=0, product=0; no done pulse follows; a subsequent op 2*2 -> product=0x0004.
- With MUL_16_SEQ_EARLY_TERM_EN:
  - a=0x00AB, b=1 -> done in cycle 2, product=0x00AB.
  - b=0x0010 -> done in cycle 6.
  - b=0 -> done in cycle 2, product=0.
  - Without the macro, the same stimulus gives done in cycle 17 with identical products.

Source files
------------

// File: rtl/mul_16_seq.sv
// Sequential 16x16 shift-and-add multiplier returning the low 16 product bits.
// Optional early exit once the remaining multiplier bits are zero: MUL_16_SEQ_EARLY_TERM_EN.

module add_16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  assign sum = a + b;
endmodule

module mul_16_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  generate
    if (WIDTH != 16) begin : g_width_check
      $error("mul_16_seq: only WIDTH=16 is supported");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_r;
  state_t      state_nx_s;
  logic [15:0] mcand_r;
  logic [15:0] mplier_r;
  logic [15:0] acc_r;
  logic [15:0] product_r;
  logic [3:0]  count_r;
  logic        ready_r;
  logic        busy_r;
  logic        done_r;
  logic [15:0] sum_s;
  logic [15:0] acc_step_s;
  logic        last_s;

  add_16 u_add (
    .a   (acc_r),
    .b   (mcand_r),
    .sum (sum_s)
  );

  // Accumulate step for the current multiplier bit and the RUN exit condition.
  always_comb begin
    acc_step_s = acc_r;
    last_s     = 1'b0;
    if (mplier_r[0]) begin
      acc_step_s = sum_s;
    end else begin
      acc_step_s = acc_r;
    end
`ifdef MUL_16_SEQ_EARLY_TERM_EN
    last_s = (count_r == 4'd15) || (mplier_r[15:1] == 15'd0);
`else
    last_s = (count_r == 4'd15);
`endif
  end

  // Next-state logic.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_nx_s = RUN;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // State register and handshake outputs, registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      ready_r <= 1'b1;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nx_s;
      ready_r <= (state_nx_s == IDLE);
      busy_r  <= (state_nx_s == RUN) || (state_nx_s == DONE);
      done_r  <= (state_nx_s == DONE);
    end
  end

  // Shift-and-add datapath; product captures the final accumulate on entry to DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r   <= 16'd0;
      mplier_r  <= 16'd0;
      acc_r     <= 16'd0;
      count_r   <= 4'd0;
      product_r <= 16'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (start) begin
            mcand_r  <= a;
            mplier_r <= b;
            acc_r    <= 16'd0;
            count_r  <= 4'd0;
          end
        end
        RUN: begin
          acc_r    <= acc_step_s;
          mcand_r  <= {mcand_r[14:0], 1'b0};
          mplier_r <= {1'b0, mplier_r[15:1]};
          count_r  <= count_r + 4'd1;
          if (last_s) begin
            product_r <= acc_step_s;
          end
        end
        DONE: begin
          count_r <= count_r;
        end
        default: begin
          count_r <= 4'd0;
        end
      endcase
    end
  end

  assign ready   = ready_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign product = product_r;

endmodule

// File: tb/tb_mul_16_seq.sv
// Directed self-checking bench for mul_16_seq; cycle 0 is the cycle start is accepted.

module tb_mul_16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] a;
  logic [15:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [15:0] product;

  int checks = 0;
  int errors = 0;

  mul_16_seq #(.WIDTH(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected cycle of the done pulse for multiplier bv.
  function automatic int exp_cycle(input logic [15:0] bv);
    int m;
    m = 0;
`ifdef MUL_16_SEQ_EARLY_TERM_EN
    for (int i = 0; i < 16; i++) if (bv[i]) m = i;
    return m + 2;
`else
    m = bv[0];
    return 17 + m - m;
`endif
  endfunction

  // Drive cycle 0 with a start request; returns positioned in cycle 1.
  task automatic launch(input logic [15:0] av, input logic [15:0] bv);
    @(posedge clk); #1;
    start = 1'b1; a = av; b = bv;
    @(posedge clk); #1;
  endtask

  // Observe ncyc cycles starting at cycle 1; optional stray start or held start.
  task automatic watch(input int ncyc, input int ign_cyc, input int hold_until,
                       output int d1, output int d2, output int pulses,
                       output logic [15:0] p1, output logic [15:0] p2,
                       output logic rdy_after);
    d1 = -1; d2 = -1; pulses = 0; p1 = 16'hxxxx; p2 = 16'hxxxx; rdy_after = 1'bx;
    for (int c = 1; c <= ncyc; c++) begin
      if (c <= hold_until) begin
        start = 1'b1; a = 16'd2; b = 16'h8000;
      end else if (c == ign_cyc) begin
        start = 1'b1; a = 16'd1; b = 16'd1;
      end else begin
        start = 1'b0; a = 16'($urandom); b = 16'($urandom);
      end
      @(negedge clk);
      if (d1 >= 0 && c == d1 + 1) rdy_after = ready;
      if (done === 1'b1) begin
        pulses++;
        if (d1 < 0) begin d1 = c; p1 = product; end
        else if (d2 < 0) begin d2 = c; p2 = product; end
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = 16'd0; b = 16'd0;
    #12;
    checks++;
    if ({ready, busy, done} !== 3'b100 || product !== 16'd0) begin
      errors++;
      $display("FAIL reset_state: got rdy/busy/done=%b%b%b product=%h, want 100 0000",
               ready, busy, done, product);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_op(input logic [15:0] av, input logic [15:0] bv,
                         input logic [15:0] ep, input string nm);
    int d1, d2, pulses; logic [15:0] p1, p2; logic ra;
    int ec;
    ec = exp_cycle(bv);
    launch(av, bv);
    watch(22, -1, 0, d1, d2, pulses, p1, p2, ra);
    checks++;
    if (d1 !== ec || pulses !== 1) begin
      errors++;
      $display("FAIL %s_timing: done cycle %0d pulses %0d, want cycle %0d pulses 1", nm, d1, pulses, ec);
    end
    checks++;
    if (p1 !== ep) begin
      errors++;
      $display("FAIL %s_product: got %h want %h", nm, p1, ep);
    end
    checks++;
    if (ra !== 1'b1 || product !== ep) begin
      errors++;
      $display("FAIL %s_after: ready=%b held product=%h, want 1 and %h", nm, ra, product, ep);
    end
  endtask

  task automatic test_ignored_start();
    int d1, d2, pulses; logic [15:0] p1, p2; logic ra;
    launch(16'd7, 16'd9);
    watch(22, 5, 0, d1, d2, pulses, p1, p2, ra);
    checks++;
    if (d1 !== exp_cycle(16'd9) || pulses !== 1 || p1 !== 16'h003F) begin
      errors++;
      $display("FAIL ignored_start: cycle %0d pulses %0d product %h, want %0d 1 003f",
               d1, pulses, p1, exp_cycle(16'd9));
    end
  endtask

  task automatic test_back_to_back();
    int d1, d2, pulses; logic [15:0] p1, p2; logic ra;
    launch(16'd3, 16'h8000);
    watch(40, -1, 35, d1, d2, pulses, p1, p2, ra);
    checks++;
    if (d1 !== 17 || d2 !== 35 || pulses !== 2) begin
      errors++;
      $display("FAIL held_start_timing: dones %0d,%0d pulses %0d, want 17,35 2", d1, d2, pulses);
    end
    checks++;
    if (p1 !== 16'h8000 || p2 !== 16'h0000) begin
      errors++;
      $display("FAIL held_start_product: got %h,%h want 8000,0000", p1, p2);
    end
  endtask

  task automatic test_reset_mid_run();
    int d1, d2, pulses; logic [15:0] p1, p2; logic ra;
    launch(16'h1234, 16'h00FF);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({ready, busy, done} !== 3'b100 || product !== 16'd0) begin
      errors++;
      $display("FAIL reset_mid_run: got rdy/busy/done=%b%b%b product=%h, want 100 0000",
               ready, busy, done, product);
    end
    @(negedge clk); rst_n = 1'b1;
    watch(20, -1, 0, d1, d2, pulses, p1, p2, ra);
    checks++;
    if (pulses !== 0 || product !== 16'd0) begin
      errors++;
      $display("FAIL reset_no_done: pulses %0d product %h, want 0 0000", pulses, product);
    end
    test_op(16'd2, 16'd2, 16'h0004, "after_reset");
  endtask

  initial begin
    test_reset();
    test_op(16'd3, 16'd5, 16'h000F, "basic");
    test_op(16'hFFFF, 16'hFFFF, 16'h0001, "all_ones");
    test_op(16'd300, 16'd300, 16'h5F90, "wrap");
    test_op(16'hFFFD, 16'h0007, 16'hFFEB, "signed");
    test_op(16'h8000, 16'h0002, 16'h0000, "msb_shift");
    test_ignored_start();
    test_reset_mid_run();
    test_op(16'h00AB, 16'h0001, 16'h00AB, "b_one");
    test_op(16'h00AB, 16'h0010, 16'h0AB0, "b_16");
    test_op(16'h00AB, 16'h0000, 16'h0000, "b_zero");
    test_op(16'h0000, 16'h1234, 16'h0000, "a_zero");
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
